// File: rtl/proc_pkg.sv
// Shared processor-debug types: the halt dump FSM state encoding.
// The CSUM state exists only when HALT_DUMP_CHECKSUM_EN is defined.
package proc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SEND,
`ifdef HALT_DUMP_CHECKSUM_EN
      CSUM,
`endif
      DONE
   } dump_state_t;

endpackage

// File: rtl/halt_dump_engine.sv
// Streams the register file out over a valid/ready port after a halt rising edge.
// Optional trailing XOR checksum word when HALT_DUMP_CHECKSUM_EN is defined.
module halt_dump_engine
   import proc_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int NUM_REGS = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        halt,
   output logic [$clog2(NUM_REGS)-1:0] rf_rd_addr,
   input  logic [DATA_W-1:0]           rf_rd_data,
   output logic [DATA_W-1:0]           out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        stall_req,
   output logic                        done
);

   localparam int ADDR_W = $clog2(NUM_REGS);
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   dump_state_t       state;
   logic [ADDR_W-1:0] index;
   logic              halt_q;
   logic              armed;
   logic              xfer;
`ifdef HALT_DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] checksum;
`endif

   assign rf_rd_addr = index;
   assign xfer       = out_valid & out_ready;

   // armed stays low for the first cycle after reset so a halt that is
   // already high when reset releases is not mistaken for a rising edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         index     <= '0;
         halt_q    <= 1'b0;
         armed     <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         stall_req <= 1'b0;
         done      <= 1'b0;
`ifdef HALT_DUMP_CHECKSUM_EN
         checksum  <= '0;
`endif
      end else begin
         halt_q <= halt;
         armed  <= 1'b1;
         case (state)
            IDLE: begin
               if (armed && halt && !halt_q) begin
                  index     <= '0;
                  stall_req <= 1'b1;
                  state     <= LOAD;
`ifdef HALT_DUMP_CHECKSUM_EN
                  checksum  <= '0;
`endif
               end
            end
            LOAD: begin
               out_data  <= rf_rd_data;
               out_valid <= 1'b1;
               state     <= SEND;
            end
            SEND: begin
               if (xfer) begin
                  out_valid <= 1'b0;
`ifdef HALT_DUMP_CHECKSUM_EN
                  checksum  <= checksum ^ out_data;
`endif
                  if (index != LAST_IDX) begin
                     index <= index + ADDR_W'(1);
                     state <= LOAD;
                  end else begin
`ifdef HALT_DUMP_CHECKSUM_EN
                     state <= CSUM;
`else
                     done  <= 1'b1;
                     state <= DONE;
`endif
                  end
               end
            end
`ifdef HALT_DUMP_CHECKSUM_EN
            // First CSUM cycle loads the word, then it waits for its handshake.
            CSUM: begin
               if (!out_valid) begin
                  out_data  <= checksum;
                  out_valid <= 1'b1;
               end else if (xfer) begin
                  out_valid <= 1'b0;
                  done      <= 1'b1;
                  state     <= DONE;
               end
            end
`endif
            DONE: begin
               if (!halt) begin
                  done      <= 1'b0;
                  stall_req <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               done      <= 1'b0;
               stall_req <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_halt_dump_engine.sv
// Bench for halt_dump_engine: table of dump scenarios checked against a
// queue-based model, plus reset, release and small-parameter sequences.
module tb_halt_dump_engine;

   localparam int NR = 32;

   logic        clk = 1'b0;
   logic        rst, halt, out_ready, out_valid, stall_req, done;
   logic [4:0]  rf_rd_addr;
   logic [31:0] rf_rd_data, out_data;
   logic [31:0] rf [NR];

   logic        halt2, ready2, valid2, stall2, done2;
   logic [0:0]  addr2;
   logic [15:0] rdata2, data2;
   logic [15:0] rf2 [2];

   assign rf_rd_data = rf[rf_rd_addr];
   assign rdata2     = rf2[addr2];

   always #5 clk = ~clk;

   halt_dump_engine dut (
      .clk(clk), .rst(rst), .halt(halt), .rf_rd_addr(rf_rd_addr),
      .rf_rd_data(rf_rd_data), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .stall_req(stall_req), .done(done)
   );

   halt_dump_engine #(.DATA_W(16), .NUM_REGS(2)) dut_small (
      .clk(clk), .rst(rst), .halt(halt2), .rf_rd_addr(addr2),
      .rf_rd_data(rdata2), .out_data(data2), .out_valid(valid2),
      .out_ready(ready2), .stall_req(stall2), .done(done2)
   );

   int checks = 0;
   int failures = 0;
   logic [31:0] got [$];
   logic [15:0] got2 [$];
   int max_addr = 0;
   int max_addr2 = 0;

   // Sink side: record every accepted word.
   always @(posedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) got.push_back(out_data);
         if (valid2 && ready2) got2.push_back(data2);
         if (int'(rf_rd_addr) > max_addr) max_addr = int'(rf_rd_addr);
         if (int'(addr2) > max_addr2) max_addr2 = int'(addr2);
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic load_pattern(input int pat);
      for (int i = 0; i < NR; i++) begin
         case (pat)
            0:       rf[i] = 32'h11111111 * i;
            1:       rf[i] = i;
            2:       rf[i] = (i == 3) ? 32'hFFFFFFFF : 32'h0;
            default: rf[i] = $urandom();
         endcase
      end
   endtask

   // mode 0: always ready, 1: random ready, 2: stall stall_len cycles at word stall_at.
   task automatic run_dump(input int mode, input int stall_at, input int stall_len, input int toggle_at);
      logic [31:0] exp [$];
      logic [31:0] x;
      int stalled;
      int tphase;
      int cyc;
      int n;
      x = '0; stalled = 0; tphase = 0; cyc = 0;
      for (int i = 0; i < NR; i++) begin
         exp.push_back(rf[i]);
         x ^= rf[i];
      end
`ifdef HALT_DUMP_CHECKSUM_EN
      exp.push_back(x);
`endif
      got.delete();
      max_addr = 0;
      @(negedge clk);
      halt = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      check("stall_req_after_edge", stall_req, 1);
      check("valid_after_1_cycle", out_valid, 0);
      @(negedge clk);
      check("valid_after_2_cycles", out_valid, 1);
      check("first_word", out_data, exp[0]);
      while (!done && cyc < 3000) begin
         case (mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            default: begin
               if (got.size() == stall_at && out_valid && stalled < stall_len) begin
                  check("held_word", out_data, exp[stall_at]);
                  out_ready = 1'b0;
                  stalled++;
               end else begin
                  out_ready = 1'b1;
               end
            end
         endcase
         if (toggle_at >= 0) begin
            if (tphase == 0 && got.size() == toggle_at) begin
               halt = 1'b0;
               tphase = 1;
            end else if (tphase == 1) begin
               halt = 1'b1;
               tphase = 2;
            end
         end
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 3000) begin
         failures++;
         $display("FAIL dump_timeout: done never asserted within 3000 cycles");
      end
      check("done_reached", done, 1);
      check("word_count", got.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         check($sformatf("word_%0d", i), got[i], exp[i]);
      if (mode == 2) check("stall_cycles", stalled, stall_len);
      check("max_rd_addr", max_addr, NR - 1);
      n = got.size();
      repeat (3) @(negedge clk);
      check("done_held", {done, stall_req, out_valid}, 3'b110);
      check("no_extra_words", got.size(), n);
      halt = 1'b0;
      @(negedge clk);
      check("release_idle", {done, stall_req}, 2'b00);
   endtask

   typedef struct {
      int          pat;
      int          mode;
      int          stall_at;
      int          stall_len;
      int          toggle_at;
      bit          chk_const;
      logic [31:0] w5;
      logic [31:0] last;
      bit          chk_csum;
      logic [31:0] csum;
   } vec_t;

   vec_t tbl [7];
   int cyc;
   int n;

   initial begin
      tbl[0] = '{0, 0, 0,  0, -1, 1'b1, 32'h55555555, 32'h1111110F, 1'b0, 32'h0};
      tbl[1] = '{0, 2, 5,  7, -1, 1'b1, 32'h55555555, 32'h1111110F, 1'b0, 32'h0};
      tbl[2] = '{1, 0, 0,  0, -1, 1'b1, 32'h00000005, 32'h0000001F, 1'b1, 32'h00000000};
      tbl[3] = '{2, 1, 0,  0, -1, 1'b1, 32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF};
      tbl[4] = '{0, 0, 0,  0,  3, 1'b1, 32'h55555555, 32'h1111110F, 1'b0, 32'h0};
      tbl[5] = '{3, 1, 0,  0, -1, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0};
      tbl[6] = '{3, 2, 20, 3, -1, 1'b0, 32'h0,        32'h0,        1'b0, 32'h0};

      rst = 1'b1; halt = 1'b0; out_ready = 1'b1;
      halt2 = 1'b0; ready2 = 1'b1;
      rf2[0] = 16'hA5A5; rf2[1] = 16'h5A5A;
      load_pattern(0);
      repeat (2) @(negedge clk);
      check("reset_outputs", {out_valid, stall_req, done}, 3'b000);
      check("reset_addr", rf_rd_addr, 0);
      check("reset_data", out_data, 0);

      // Halt already high when reset releases: no dump may start.
      halt = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("no_start_on_level", {stall_req, out_valid}, 2'b00);
      halt = 1'b0;
      @(negedge clk);

      for (int t = 0; t < 7; t++) begin
         load_pattern(tbl[t].pat);
         run_dump(tbl[t].mode, tbl[t].stall_at, tbl[t].stall_len, tbl[t].toggle_at);
         if (tbl[t].chk_const && got.size() >= NR) begin
            check($sformatf("vec%0d_word5", t), got[5], tbl[t].w5);
            check($sformatf("vec%0d_last", t), got[NR-1], tbl[t].last);
         end
`ifdef HALT_DUMP_CHECKSUM_EN
         if (tbl[t].chk_csum && got.size() == NR + 1)
            check($sformatf("vec%0d_csum", t), got[NR], tbl[t].csum);
`endif
      end

      // Reset mid-dump after word 10, then restart from r0.
      load_pattern(0);
      got.delete();
      out_ready = 1'b1;
      @(negedge clk);
      halt = 1'b1;
      cyc = 0;
      while (got.size() < 11 && cyc < 500) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 500) begin
         failures++;
         $display("FAIL midreset_timeout: only %0d words seen, required 11", got.size());
      end
      rst = 1'b1;
      halt = 1'b0;
      @(negedge clk);
      check("midreset_outputs", {out_valid, stall_req, done}, 3'b000);
      check("midreset_addr", rf_rd_addr, 0);
      n = got.size();
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check("midreset_no_words", got.size(), n);
      run_dump(0, 0, 0, -1);

      // Smallest configuration.
      got2.delete();
      max_addr2 = 0;
      @(negedge clk);
      halt2 = 1'b1;
      cyc = 0;
      while (!done2 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      if (cyc >= 200) begin
         failures++;
         $display("FAIL small_timeout: done never asserted");
      end
      check("small_done", done2, 1);
`ifdef HALT_DUMP_CHECKSUM_EN
      check("small_count", got2.size(), 3);
      if (got2.size() == 3) check("small_csum", got2[2], 16'hFFFF);
`else
      check("small_count", got2.size(), 2);
`endif
      if (got2.size() >= 2) begin
         check("small_word0", got2[0], 16'hA5A5);
         check("small_word1", got2[1], 16'h5A5A);
      end
      check("small_max_addr", max_addr2, 1);
      halt2 = 1'b0;
      @(negedge clk);
      check("small_release", {done2, stall2}, 2'b00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
